sound_poly: RTL and testbench

//  Parametrised multi-channel square-wave sound generator; next generation of the single-buzzer block.
//  CPU latches a half-period count and an optional note duration into any of NUM_CHANNELS voices.

---
 rtl/sound_pkg.sv | 13 +
 rtl/sound_channel.sv | 73 +++++++
 rtl/sound_poly.sv | 89 ++++++++
 tb/tb_sound_poly.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared constants and helpers for the square-wave sound generators.
package sound_pkg;

    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int          DEFAULT_COUNT_WIDTH = 26;
    localparam int          DEFAULT_DUR_WIDTH   = 16;

    // Half-period count that produces a tone of f Hz from CLK_HZ.
    function automatic int unsigned hz_to_count(input int unsigned f);
        return CLK_HZ / (2 * f) - 1;
    endfunction

endpackage

// File: rtl/sound_channel.sv
// One square-wave voice: half-period counter, toggle and optional note countdown.
// Countdown logic present only when SOUND_POLY_DURATION_EN is defined.
module sound_channel
    import sound_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int DUR_WIDTH   = DEFAULT_DUR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic                   load,
`ifdef SOUND_POLY_DURATION_EN
    input  logic                   tick,
    input  logic [DUR_WIDTH-1:0]   duration,
`endif
    input  logic [COUNT_WIDTH-1:0] max_count,
    output logic                   active,
    output logic                   wave
);

    logic [COUNT_WIDTH-1:0] period_reg;
    logic [COUNT_WIDTH-1:0] counter;
    logic                   toggle;
`ifdef SOUND_POLY_DURATION_EN
    logic [DUR_WIDTH-1:0]   remaining;
`endif

    assign active = (period_reg != '0);
    assign wave   = toggle & active;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            period_reg <= '0;
            counter    <= '0;
            toggle     <= 1'b0;
`ifdef SOUND_POLY_DURATION_EN
            remaining  <= '0;
`endif
        end else if (load) begin
            // A load restarts the phase and overrides any tick this cycle.
            period_reg <= max_count;
            counter    <= '0;
            toggle     <= 1'b0;
`ifdef SOUND_POLY_DURATION_EN
            remaining  <= duration;
`endif
        end else begin
            if (active) begin
                if (counter >= period_reg) begin
                    counter <= '0;
                    toggle  <= ~toggle;
                end else begin
                    counter <= counter + COUNT_WIDTH'(1);
                end
            end else begin
                counter <= '0;
                toggle  <= 1'b0;
            end
`ifdef SOUND_POLY_DURATION_EN
            // remaining==0 marks an untimed note and is never counted down.
            if (tick && active && (remaining != '0)) begin
                if (remaining == DUR_WIDTH'(1)) begin
                    remaining  <= '0;
                    period_reg <= '0;
                end else begin
                    remaining <= remaining - DUR_WIDTH'(1);
                end
            end
`endif
        end
    end

endmodule

// File: rtl/sound_poly.sv
// Multi-voice square-wave generator with a PWM mix onto one buzzer bit.
// SOUND_POLY_DURATION_EN adds the ms-tick prescaler and timed-note countdown.
module sound_poly
    import sound_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH,
    parameter int DUR_WIDTH    = DEFAULT_DUR_WIDTH,
    parameter int TICK_DIV     = 50000
) (
    input  logic                                                     clk,
    input  logic                                                     rst_async,
    input  logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] ch_sel,
    input  logic [COUNT_WIDTH-1:0]                                   max_count,
    input  logic [DUR_WIDTH-1:0]                                     duration,
    input  logic                                                     latch,
    output logic [NUM_CHANNELS-1:0]                                  ch_active,
    output logic [NUM_CHANNELS-1:0]                                  ch_wave,
    output logic                                                     buzzer
);

    localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int SUM_W = $clog2(NUM_CHANNELS + 1);

    // latch is a single-cycle strobe with no back-pressure: the voice named by
    // ch_sel samples max_count/duration on that edge; out-of-range selects are dropped.
    logic [NUM_CHANNELS-1:0] load;

`ifdef SOUND_POLY_DURATION_EN
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] prescaler;
    logic             tick;

    assign tick = (prescaler == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)  prescaler <= '0;
        else if (tick)  prescaler <= '0;
        else            prescaler <= prescaler + PRE_W'(1);
    end
`else
    logic unused_duration;
    assign unused_duration = ^duration;
`endif

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign load[i] = latch && (ch_sel == SEL_W'(i));

        sound_channel #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .DUR_WIDTH   (DUR_WIDTH)
        ) u_channel (
            .clk       (clk),
            .rst_async (rst_async),
            .load      (load[i]),
`ifdef SOUND_POLY_DURATION_EN
            .tick      (tick),
            .duration  (duration),
`endif
            .max_count (max_count),
            .active    (ch_active[i]),
            .wave      (ch_wave[i])
        );
    end

    logic [SUM_W-1:0] wave_sum;
    logic [SUM_W-1:0] mix_phase;

    always_comb begin
        wave_sum = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            wave_sum = wave_sum + SUM_W'(ch_wave[i]);
        end
    end

    // mix_phase sweeps the voice slots; buzzer is high for wave_sum of every NUM_CHANNELS cycles.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            mix_phase <= '0;
            buzzer    <= 1'b0;
        end else begin
            if (mix_phase == SUM_W'(NUM_CHANNELS - 1)) mix_phase <= '0;
            else                                       mix_phase <= mix_phase + SUM_W'(1);
            buzzer <= (mix_phase < wave_sum);
        end
    end

endmodule

// File: tb/tb_sound_poly.sv
// Self-checking bench for sound_poly: behavioural voice model plus per-scenario checks.
module tb_sound_poly;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int DW  = 8;
    localparam int TD  = 8;
`ifdef SOUND_POLY_DURATION_EN
    localparam bit DUR_EN = 1'b1;
`else
    localparam bit DUR_EN = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_async = 1'b0;
    logic [1:0]    ch_sel    = '0;
    logic [CW-1:0] max_count = '0;
    logic [DW-1:0] duration  = '0;
    logic          latch     = 1'b0;

    logic [NCH-1:0] ch_active, ch_wave;
    logic           buzzer;
    logic [2:0]     ch_active3, ch_wave3;
    logic           buzzer3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sound_poly #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .DUR_WIDTH(DW), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_async(rst_async), .ch_sel(ch_sel), .max_count(max_count),
        .duration(duration), .latch(latch), .ch_active(ch_active), .ch_wave(ch_wave),
        .buzzer(buzzer)
    );

    // Three-voice instance: its 2-bit select can name a channel that does not exist.
    sound_poly #(.NUM_CHANNELS(3), .COUNT_WIDTH(CW), .DUR_WIDTH(DW), .TICK_DIV(TD)) dut3 (
        .clk(clk), .rst_async(rst_async), .ch_sel(ch_sel), .max_count(max_count),
        .duration(duration), .latch(latch), .ch_active(ch_active3), .ch_wave(ch_wave3),
        .buzzer(buzzer3)
    );

    // Reference model: each voice is a period, an age since its last load and a
    // remaining tick count; the wave level is derived arithmetically from the age.
    int             m_per[NCH];
    int             m_age[NCH];
    int             m_rem[NCH];
    int             m_edges;
    int             m_sum;
    int             m_mp;
    bit             m_tick;
    logic [NCH-1:0] exp_active, exp_wave;
    logic           exp_buz;

    always @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            m_edges = 0;
            for (int i = 0; i < NCH; i++) begin
                m_per[i] = 0; m_age[i] = 0; m_rem[i] = 0;
            end
            exp_buz = 1'b0;
        end else begin
            m_sum = 0;
            for (int i = 0; i < NCH; i++) m_sum += int'(exp_wave[i]);
            m_mp = m_edges % NCH;
            m_edges++;
            m_tick = ((m_edges % TD) == 0);
            for (int i = 0; i < NCH; i++) begin
                if (latch && int'(ch_sel) == i) begin
                    m_per[i] = int'(max_count);
                    m_rem[i] = DUR_EN ? int'(duration) : 0;
                    m_age[i] = 0;
                end else if (m_per[i] != 0) begin
                    m_age[i]++;
                    if (m_tick && m_rem[i] != 0) begin
                        if (m_rem[i] == 1) begin
                            m_rem[i] = 0; m_per[i] = 0;
                        end else begin
                            m_rem[i]--;
                        end
                    end
                end
            end
            exp_buz = (m_mp < m_sum);
        end
        for (int i = 0; i < NCH; i++) begin
            exp_active[i] = (m_per[i] != 0);
            exp_wave[i]   = exp_active[i] && (((m_age[i] / (m_per[i] + 1)) % 2) == 1);
        end
    end

    // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
    task automatic do_reset();
        @(negedge clk);
        latch     = 1'b0;
        rst_async = 1'b1;
        #2 rst_async = 1'b0;
        @(negedge clk);
    endtask

    task automatic latch_note(input int sel, input int mc, input int dur);
        ch_sel    = 2'(sel);
        max_count = CW'(mc);
        duration  = DW'(dur);
        latch     = 1'b1;
        @(negedge clk);
        latch     = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst_async = 1'b1;
        #10;
        n_tests++;
        if ({ch_active, ch_wave, buzzer} !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got act=%b wave=%b buz=%b, want all 0", ch_active, ch_wave, buzzer);
        end
        @(negedge clk);
        #2 rst_async = 1'b0;
        @(negedge clk);
        latch_note(0, 4, 0);
        repeat (6) @(negedge clk);
        n_tests++;
        if (ch_wave[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_precond: ch_wave[0]=%b, want 1", ch_wave[0]);
        end
        @(posedge clk);
        #2 rst_async = 1'b1;
        #1;
        n_tests++;
        if ({ch_active, ch_wave, buzzer} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got act=%b wave=%b buz=%b, want all 0", ch_active, ch_wave, buzzer);
        end
        #2 rst_async = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_tests++;
            if ({ch_active, ch_wave, buzzer} !== '0) begin
                n_fail++;
                $display("FAIL reset_after: got act=%b wave=%b buz=%b, want all 0", ch_active, ch_wave, buzzer);
            end
        end
    endtask

    task automatic test_tone();
        int highs = 0;
        int last_rise = -1;
        logic prev = 1'b0;
        do_reset();
        latch_note(0, 4, 0);
        for (int k = 0; k < 40; k++) begin
            n_tests++;
            if ({ch_active, ch_wave, buzzer} !== {exp_active, exp_wave, exp_buz}) begin
                n_fail++;
                $display("FAIL tone_model: act=%b wave=%b buz=%b, want act=%b wave=%b buz=%b",
                         ch_active, ch_wave, buzzer, exp_active, exp_wave, exp_buz);
            end
            n_tests++;
            if (ch_active[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL tone_active: ch_active[0]=%b at age %0d, want 1", ch_active[0], k);
            end
            if (ch_wave[0] === 1'b1) highs++;
            if (ch_wave[0] === 1'b1 && prev === 1'b0) begin
                if (last_rise >= 0) begin
                    n_tests++;
                    if (k - last_rise != 10) begin
                        n_fail++;
                        $display("FAIL tone_period: rise spacing %0d, want 10", k - last_rise);
                    end
                end
                last_rise = k;
            end
            prev = ch_wave[0];
            @(negedge clk);
        end
        n_tests++;
        if (highs != 20) begin
            n_fail++;
            $display("FAIL tone_duty: %0d high cycles of 40, want 20", highs);
        end
    endtask

    task automatic test_timed();
        int t3;
        logic want;
        do_reset();
        latch_note(1, 2, 3);
        t3 = (m_edges / TD + 3) * TD;
        repeat (40) begin
            want = DUR_EN ? (m_edges < t3) : 1'b1;
            n_tests++;
            if (ch_active[1] !== want) begin
                n_fail++;
                $display("FAIL timed_active: edge %0d ch_active[1]=%b, want %b", m_edges, ch_active[1], want);
            end
            n_tests++;
            if ({ch_active, ch_wave, buzzer} !== {exp_active, exp_wave, exp_buz}) begin
                n_fail++;
                $display("FAIL timed_model: act=%b wave=%b buz=%b, want act=%b wave=%b buz=%b",
                         ch_active, ch_wave, buzzer, exp_active, exp_wave, exp_buz);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mix();
        int highs = 0;
        do_reset();
        latch_note(0, 20, 0);
        latch_note(2, 20, 0);
        repeat (22) begin
            n_tests++;
            if ({ch_active, ch_wave, buzzer} !== {exp_active, exp_wave, exp_buz}) begin
                n_fail++;
                $display("FAIL mix2_model: act=%b wave=%b buz=%b, want act=%b wave=%b buz=%b",
                         ch_active, ch_wave, buzzer, exp_active, exp_wave, exp_buz);
            end
            @(negedge clk);
        end
        repeat (8) begin
            if (buzzer === 1'b1) highs++;
            @(negedge clk);
        end
        n_tests++;
        if (highs != 4) begin
            n_fail++;
            $display("FAIL mix2_duty: buzzer high %0d of 8, want 4", highs);
        end
        do_reset();
        for (int c = 0; c < NCH; c++) latch_note(c, 20, 0);
        repeat (22) @(negedge clk);
        repeat (8) begin
            n_tests++;
            if (buzzer !== 1'b1) begin
                n_fail++;
                $display("FAIL mix4_full: buzzer=%b wave=%b, want 1", buzzer, ch_wave);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_silence_ignore();
        do_reset();
        latch_note(0, 4, 0);
        repeat (3) @(negedge clk);
        latch_note(0, 0, 0);
        n_tests++;
        if (ch_active[0] !== 1'b0 || ch_wave[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL silence: act0=%b wave0=%b, want 0 0", ch_active[0], ch_wave[0]);
        end
        do_reset();
        latch_note(3, 4, 0);
        n_tests++;
        if (ch_active !== 4'b1000) begin
            n_fail++;
            $display("FAIL sel3_wide: ch_active=%b, want 1000", ch_active);
        end
        repeat (10) begin
            n_tests++;
            if ({ch_active3, ch_wave3, buzzer3} !== '0) begin
                n_fail++;
                $display("FAIL sel_ignored: act3=%b wave3=%b buz3=%b, want all 0", ch_active3, ch_wave3, buzzer3);
            end
            @(negedge clk);
        end
        latch_note(0, 4, 0);
        n_tests++;
        if (ch_active3 !== 3'b001) begin
            n_fail++;
            $display("FAIL sel_valid: act3=%b, want 001", ch_active3);
        end
    endtask

    task automatic test_latch_on_tick();
        int guard = 0;
        do_reset();
        while ((m_edges % TD) != 0 && guard < 2 * TD) begin
            @(negedge clk); guard++;
        end
        latch_note(1, 3, 1);
        guard = 0;
        while (((m_edges + 1) % TD) != 0 && guard < 2 * TD) begin
            @(negedge clk); guard++;
        end
        n_tests++;
        if (((m_edges + 1) % TD) != 0) begin
            n_fail++;
            $display("FAIL tick_align: could not reach tick edge, edges=%0d", m_edges);
        end
        latch_note(1, 5, 2);
        n_tests++;
        if (ch_active[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL latch_wins: ch_active[1]=%b, want 1", ch_active[1]);
        end
        repeat (30) begin
            n_tests++;
            if ({ch_active, ch_wave, buzzer} !== {exp_active, exp_wave, exp_buz}) begin
                n_fail++;
                $display("FAIL tick_model: act=%b wave=%b buz=%b, want act=%b wave=%b buz=%b",
                         ch_active, ch_wave, buzzer, exp_active, exp_wave, exp_buz);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (400) begin
            n_tests++;
            if ({ch_active, ch_wave, buzzer} !== {exp_active, exp_wave, exp_buz}) begin
                n_fail++;
                $display("FAIL random_model: edge %0d act=%b wave=%b buz=%b, want act=%b wave=%b buz=%b",
                         m_edges, ch_active, ch_wave, buzzer, exp_active, exp_wave, exp_buz);
            end
            if ($urandom_range(0, 9) < 3) begin
                ch_sel    = 2'($urandom_range(0, NCH - 1));
                max_count = CW'($urandom_range(0, 9));
                duration  = DW'($urandom_range(0, 4));
                latch     = 1'b1;
            end else begin
                latch = 1'b0;
            end
            @(negedge clk);
        end
        latch = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tone();
        test_timed();
        test_mix();
        test_silence_ignore();
        test_latch_on_tick();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
